// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipeline_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  localparam int         MD_CYCLES_DEF = 8;
  localparam int         CNT_W         = 6;
  localparam int         STALL_CNT_W   = 16;
  localparam logic [4:0] REG_ZERO      = 5'd0;

  // True when the ID instruction reads src and src matches the EX destination.
  function automatic logic src_match(input logic uses, input logic [4:0] src,
                                     input logic [4:0] dst);
    return uses && (src == dst);
  endfunction

endpackage

// File: rtl/md_cycle_counter.sv
// Loadable 6-bit down-counter timing a multi-cycle mult/div operation.
module md_cycle_counter
  import pipeline_pkg::*;
(
  input  logic             clk,
  input  logic             clrn,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero_next
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  // Asserted in the cycle whose decrement brings the count to zero.
  assign zero_next = dec && (count == CNT_W'(1));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use and mult/div stall control, branch flush and stall statistics.
//
// state   | meaning
// IDLE    | no mult/div active; a new one may start this cycle
// MD_RUN  | mult/div executing, pipeline held
// MD_DONE | result available, stall released for one cycle
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int MD_CYCLES = MD_CYCLES_DEF
) (
  input  logic                   clk,
  input  logic                   clrn,
  input  logic [4:0]             id_rs,
  input  logic [4:0]             id_rt,
  input  logic                   id_uses_rs,
  input  logic                   id_uses_rt,
  input  logic                   id_muldiv,
  input  logic                   id_branch_taken,
  input  logic                   ex_m2reg,
  input  logic                   ex_wreg,
  input  logic [4:0]             ex_rd,
  output logic                   stall,
  output logic                   id_bubble,
  output logic                   if_flush,
  output logic                   md_busy,
  output logic                   md_done,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_CYCLES - 1);

  md_state_t state, state_nxt;
  logic      load_use;
  logic      md_start;
  logic      cnt_dec;
  logic      cnt_zero_next;

  assign load_use = ex_m2reg && ex_wreg && (ex_rd != REG_ZERO) &&
                    (src_match(id_uses_rs, id_rs, ex_rd) ||
                     src_match(id_uses_rt, id_rt, ex_rd));

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A load-use hazard defers the start; the ID instruction is re-examined next cycle.
  always_comb begin
    state_nxt = state;
    md_start  = 1'b0;
    case (state)
      IDLE: begin
        if (id_muldiv && !load_use) begin
          md_start  = 1'b1;
          state_nxt = MD_RUN;
        end
      end
      MD_RUN: begin
        if (cnt_zero_next) begin
          state_nxt = MD_DONE;
        end
      end
      MD_DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign cnt_dec = (state == MD_RUN);

  md_cycle_counter u_md_cycle_counter (
    .clk       (clk),
    .clrn      (clrn),
    .load      (md_start),
    .load_val  (MD_LOAD),
    .dec       (cnt_dec),
    .zero_next (cnt_zero_next)
  );

  assign md_busy   = (state == MD_RUN);
  assign md_done   = (state == MD_DONE);
  assign stall     = load_use || md_busy || md_start;
  assign id_bubble = stall;
  assign if_flush  = id_branch_taken && !stall;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != {STALL_CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl with a cycle-phase reference model.
module tb_pipeline_hazard_ctrl;

  localparam int MD_CYCLES = 8;

  logic        clk;
  logic        clrn;
  logic [4:0]  id_rs, id_rt, ex_rd;
  logic        id_uses_rs, id_uses_rt, id_muldiv, id_branch_taken;
  logic        ex_m2reg, ex_wreg;
  logic        stall, id_bubble, if_flush, md_busy, md_done;
  logic [15:0] stall_cycles;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: remaining busy cycles, done phase, saturating stall count
  int m_run_left = 0;
  bit m_done     = 0;
  int m_scnt     = 0;
  bit e_stall, e_flush, e_busy, e_done, e_start;

  pipeline_hazard_ctrl #(.MD_CYCLES(MD_CYCLES)) dut (
    .clk             (clk),
    .clrn            (clrn),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rs      (id_uses_rs),
    .id_uses_rt      (id_uses_rt),
    .id_muldiv       (id_muldiv),
    .id_branch_taken (id_branch_taken),
    .ex_m2reg        (ex_m2reg),
    .ex_wreg         (ex_wreg),
    .ex_rd           (ex_rd),
    .stall           (stall),
    .id_bubble       (id_bubble),
    .if_flush        (if_flush),
    .md_busy         (md_busy),
    .md_done         (md_done),
    .stall_cycles    (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_eval();
    bit lu, idle;
    lu = ex_m2reg && ex_wreg && (ex_rd != 0) &&
         ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
    idle    = (m_run_left == 0) && !m_done;
    e_busy  = (m_run_left > 0);
    e_done  = m_done;
    e_start = idle && id_muldiv && !lu;
    e_stall = lu || e_busy || e_start;
    e_flush = id_branch_taken && !e_stall;
  endfunction

  function automatic void model_edge();
    model_eval();
    if (e_stall && m_scnt < 65535) m_scnt++;
    if (m_run_left > 0) begin
      m_run_left--;
      if (m_run_left == 0) m_done = 1;
    end else if (m_done) begin
      m_done = 0;
    end else if (e_start) begin
      m_run_left = MD_CYCLES - 1;
    end
  endfunction

  function automatic void model_reset();
    m_run_left = 0;
    m_done     = 0;
    m_scnt     = 0;
  endfunction

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                       input logic urt, input logic md, input logic br,
                       input logic m2r, input logic wr, input logic [4:0] rd);
    id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    id_muldiv = md; id_branch_taken = br; ex_m2reg = m2r; ex_wreg = wr; ex_rd = rd;
  endtask

  task automatic advance();
    @(posedge clk);
    if (clrn) model_edge();
    #1;
  endtask

  task automatic test_reset();
    clrn = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    n_checks++; if (stall !== 1'b0) $display("FAIL reset_stall got=%b exp=0", stall); else n_pass++;
    n_checks++; if (md_busy !== 1'b0 || md_done !== 1'b0)
      $display("FAIL reset_md got=%b%b exp=00", md_busy, md_done); else n_pass++;
    n_checks++; if (stall_cycles !== 16'h0) $display("FAIL reset_scnt got=%h exp=0000", stall_cycles); else n_pass++;
    id_muldiv = 1'b1;
    #1;
    n_checks++; if (stall !== 1'b1) $display("FAIL reset_comb_stall got=%b exp=1", stall); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (stall_cycles !== 16'h0 || md_busy !== 1'b0)
      $display("FAIL reset_hold got=%h/%b exp=0000/0", stall_cycles, md_busy); else n_pass++;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    clrn = 1'b1;
    model_reset();
    advance();
  endtask

  task automatic test_load_use();
    drive(5, 0, 1, 0, 0, 0, 1, 1, 5);
    @(negedge clk);
    n_checks++; if (stall !== 1'b1 || id_bubble !== 1'b1)
      $display("FAIL lu_rs got=%b%b exp=11", stall, id_bubble); else n_pass++;
    advance();
    drive(0, 0, 1, 0, 0, 0, 1, 1, 0);
    @(negedge clk);
    n_checks++; if (stall !== 1'b0 || id_bubble !== 1'b0)
      $display("FAIL lu_rd0 got=%b%b exp=00", stall, id_bubble); else n_pass++;
    advance();
    drive(0, 9, 0, 1, 0, 0, 1, 1, 9);
    @(negedge clk);
    n_checks++; if (stall !== 1'b1) $display("FAIL lu_rt got=%b exp=1", stall); else n_pass++;
    advance();
    drive(0, 9, 0, 0, 0, 0, 1, 1, 9);
    @(negedge clk);
    n_checks++; if (stall !== 1'b0) $display("FAIL lu_rt_unused got=%b exp=0", stall); else n_pass++;
    advance();
    drive(9, 0, 1, 0, 0, 0, 1, 0, 9);
    @(negedge clk);
    n_checks++; if (stall !== 1'b0) $display("FAIL lu_nowreg got=%b exp=0", stall); else n_pass++;
    advance();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_checks++; if (stall_cycles !== 16'(m_scnt))
      $display("FAIL lu_scnt got=%0d exp=%0d", stall_cycles, m_scnt); else n_pass++;
    advance();
  endtask

  task automatic test_muldiv();
    int ns = 0, nb = 0, nd = 0;
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      ns += int'(stall); nb += int'(md_busy); nd += int'(md_done);
      if (c == 8) begin
        n_checks++; if (md_done !== 1'b1 || stall !== 1'b0)
          $display("FAIL md_done_cycle got=%b/%b exp=1/0", md_done, stall); else n_pass++;
      end
      advance();
    end
    n_checks++; if (ns != MD_CYCLES) $display("FAIL md_stall_len got=%0d exp=%0d", ns, MD_CYCLES); else n_pass++;
    n_checks++; if (nb != MD_CYCLES - 1) $display("FAIL md_busy_len got=%0d exp=%0d", nb, MD_CYCLES - 1); else n_pass++;
    n_checks++; if (nd != 1) $display("FAIL md_done_len got=%0d exp=1", nd); else n_pass++;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_checks++; if (stall !== 1'b0 || md_busy !== 1'b0 || md_done !== 1'b0)
      $display("FAIL md_back_idle got=%b%b%b exp=000", stall, md_busy, md_done); else n_pass++;
    n_checks++; if (stall_cycles !== 16'(m_scnt))
      $display("FAIL md_scnt got=%0d exp=%0d", stall_cycles, m_scnt); else n_pass++;
    advance();
  endtask

  task automatic test_lu_delay();
    int ns = 0;
    int first_busy = -1;
    int done_at = -1;
    drive(5, 0, 1, 0, 1, 0, 1, 1, 5);
    for (int c = 0; c < 10; c++) begin
      if (c == 1) drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
      @(negedge clk);
      ns += int'(stall);
      if (md_busy === 1'b1 && first_busy < 0) first_busy = c;
      if (md_done === 1'b1 && done_at < 0) done_at = c;
      advance();
    end
    n_checks++; if (ns != MD_CYCLES + 1) $display("FAIL lud_stall_len got=%0d exp=%0d", ns, MD_CYCLES + 1); else n_pass++;
    n_checks++; if (first_busy != 2) $display("FAIL lud_first_busy got=%0d exp=2", first_busy); else n_pass++;
    n_checks++; if (done_at != MD_CYCLES + 1) $display("FAIL lud_done_at got=%0d exp=%0d", done_at, MD_CYCLES + 1); else n_pass++;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    advance();
  endtask

  task automatic test_branch_flush();
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
    @(negedge clk);
    n_checks++; if (if_flush !== 1'b1) $display("FAIL br_flush got=%b exp=1", if_flush); else n_pass++;
    advance();
    drive(3, 0, 1, 0, 0, 1, 1, 1, 3);
    @(negedge clk);
    n_checks++; if (if_flush !== 1'b0 || stall !== 1'b1)
      $display("FAIL br_lu got=%b/%b exp=0/1", if_flush, stall); else n_pass++;
    advance();
    drive(0, 0, 0, 0, 1, 1, 0, 0, 0);
    @(negedge clk);
    n_checks++; if (if_flush !== 1'b0) $display("FAIL br_md_start got=%b exp=0", if_flush); else n_pass++;
    advance();
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
    @(negedge clk);
    n_checks++; if (if_flush !== 1'b0 || md_busy !== 1'b1)
      $display("FAIL br_md_run got=%b/%b exp=0/1", if_flush, md_busy); else n_pass++;
    advance();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (MD_CYCLES + 1) advance();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)));
      @(negedge clk);
      model_eval();
      n_checks++;
      if (stall !== e_stall || id_bubble !== e_stall || if_flush !== e_flush ||
          md_busy !== e_busy || md_done !== e_done || stall_cycles !== 16'(m_scnt))
        $display("FAIL rnd cyc=%0d got=%b%b%b%b%b/%0d exp=%b%b%b%b%b/%0d", c,
                 stall, id_bubble, if_flush, md_busy, md_done, stall_cycles,
                 e_stall, e_stall, e_flush, e_busy, e_done, m_scnt);
      else n_pass++;
      advance();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (MD_CYCLES + 2) advance();
  endtask

  task automatic test_reset_mid_run();
    bit saw_done = 0;
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
    advance();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) advance();
    #2;
    n_checks++; if (md_busy !== 1'b1) $display("FAIL rst_pre_busy got=%b exp=1", md_busy); else n_pass++;
    clrn = 1'b0;
    #1;
    n_checks++; if (md_busy !== 1'b0 || md_done !== 1'b0 || stall !== 1'b0)
      $display("FAIL rst_async got=%b%b%b exp=000", md_busy, md_done, stall); else n_pass++;
    n_checks++; if (stall_cycles !== 16'h0) $display("FAIL rst_scnt got=%h exp=0000", stall_cycles); else n_pass++;
    repeat (12) begin
      @(negedge clk);
      if (md_done === 1'b1) saw_done = 1;
    end
    model_reset();
    clrn = 1'b1;
    for (int c = 0; c < 12; c++) begin
      advance();
      @(negedge clk);
      if (md_done === 1'b1 || md_busy === 1'b1) saw_done = 1;
    end
    n_checks++; if (saw_done) $display("FAIL rst_no_done got=1 exp=0"); else n_pass++;
    advance();
  endtask

  task automatic test_saturation();
    drive(7, 0, 1, 0, 0, 0, 1, 1, 7);
    repeat (65540) advance();
    @(negedge clk);
    n_checks++; if (stall_cycles !== 16'hFFFF) $display("FAIL sat_value got=%h exp=ffff", stall_cycles); else n_pass++;
    n_checks++; if (stall_cycles !== 16'(m_scnt))
      $display("FAIL sat_model got=%0d exp=%0d", stall_cycles, m_scnt); else n_pass++;
    advance();
    @(negedge clk);
    n_checks++; if (stall_cycles !== 16'hFFFF) $display("FAIL sat_nowrap got=%h exp=ffff", stall_cycles); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_muldiv();
    test_lu_delay();
    test_branch_flush();
    test_random();
    test_reset_mid_run();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
